// File: rtl/i281_code_loader.sv
// ---------------------------------------------------------------------------
// i281_code_loader
//
// Fills the i281 writable code memory (WORDS x 16-bit instruction words) from
// a byte-wide host stream.  An image is framed as:
//
//   HEADER, N, {hi, lo} x N, checksum
//
// where N is the word count (1..WORDS) and checksum is the XOR of every
// payload byte (hi and lo bytes only).  The CPU is held in reset from the
// moment a load starts.  It is only released when the checksum matches.  A
// rejected image leaves the CPU held and raises error.
//
// Ports
//   Clock       rising-edge system clock
//   Reset       asynchronous, active-high reset
//   start       single-cycle pulse; begins (or restarts) a load
//   in_byte     stream data byte
//   in_valid    in_byte is valid this cycle
//   in_ready    loader accepts in_byte this cycle (decoded from state only)
//   wr_en       code memory write strobe (one cycle per word)
//   wr_addr     code memory word address
//   wr_data     instruction word {hi, lo}
//   cpu_hold    holds the CPU in reset while high
//   done        image loaded and verified (level)
//   error       image rejected (level)
//   word_count  words written in the current load
// ---------------------------------------------------------------------------
module i281_code_loader #(
  parameter int         WORDS  = 32,
  parameter int         ADDR_W = 5,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT,
    HI,
    LO,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_C = {{ADDR_W{1'b0}}, 1'b1};

  state_t state_reg, state_next;

  // Datapath registers
  logic [ADDR_W:0]   count_reg, count_next;        // N, the image word count
  logic [ADDR_W-1:0] index_reg, index_next;        // next word address
  logic [7:0]        hi_reg, hi_next;              // pending high byte
  logic [7:0]        csum_reg, csum_next;          // running payload XOR
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [15:0]       wr_data_reg, wr_data_next;
  logic              cpu_hold_reg, cpu_hold_next;
  logic              done_reg, done_next;
  logic              error_reg, error_next;
  logic [ADDR_W:0]   word_count_reg, word_count_next;

  logic              ready_int;
  logic              accept;
  logic              count_ok;
  logic [ADDR_W:0]   index_inc;

  // in_ready depends on the registered state alone, so there is no
  // combinational path from in_valid back to in_ready.
  always_comb begin
    ready_int = 1'b0;
    case (state_reg)
      HDR, CNT, HI, LO, CSUM: ready_int = 1'b1;
      default:                ready_int = 1'b0;
    endcase
  end

  assign accept    = in_valid && ready_int;
  assign count_ok  = (in_byte != 8'd0) && ({24'd0, in_byte} <= WORDS);
  assign index_inc = {1'b0, index_reg} + ONE_C;

  // -------------------------------------------------------------------------
  // State register and all registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      index_reg      <= '0;
      hi_reg         <= '0;
      csum_reg       <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      cpu_hold_reg   <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      word_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      index_reg      <= index_next;
      hi_reg         <= hi_next;
      csum_reg       <= csum_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      cpu_hold_reg   <= cpu_hold_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
      word_count_reg <= word_count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    index_next      = index_reg;
    hi_next         = hi_reg;
    csum_next       = csum_reg;
    wr_en_next      = 1'b0;          // strobe is a single-cycle pulse
    wr_addr_next    = wr_addr_reg;   // address/data hold between writes
    wr_data_next    = wr_data_reg;
    cpu_hold_next   = cpu_hold_reg;
    done_next       = done_reg;
    error_next      = error_reg;
    word_count_next = word_count_reg;

    if (start) begin
      // start wins over any byte offered in the same cycle: that byte is
      // not consumed, and the load restarts from the header.
      state_next      = HDR;
      cpu_hold_next   = 1'b1;
      done_next       = 1'b0;
      error_next      = 1'b0;
      word_count_next = '0;
      csum_next       = '0;
      index_next      = '0;
    end else if (accept) begin
      case (state_reg)
        HDR: begin
          if (in_byte == HEADER) begin
            state_next = CNT;
          end else begin
            state_next = ERR;
            error_next = 1'b1;
          end
        end

        CNT: begin
          if (count_ok) begin
            // Legal counts never exceed WORDS, which fits in ADDR_W+1 bits.
            count_next = in_byte[ADDR_W:0];
            state_next = HI;
          end else begin
            state_next = ERR;
            error_next = 1'b1;
          end
        end

        HI: begin
          hi_next    = in_byte;
          csum_next  = csum_reg ^ in_byte;
          state_next = LO;
        end

        LO: begin
          wr_en_next      = 1'b1;
          wr_addr_next    = index_reg;
          wr_data_next    = {hi_reg, in_byte};
          csum_next       = csum_reg ^ in_byte;
          index_next      = index_reg + ONE_A;
          word_count_next = word_count_reg + ONE_C;
          // Compare on the widened index so a full WORDS-long image ends
          // correctly even though index itself wraps to zero.
          if (index_inc == count_reg) begin
            state_next = CSUM;
          end else begin
            state_next = HI;
          end
        end

        CSUM: begin
          if (in_byte == csum_reg) begin
            state_next    = DONE;
            done_next     = 1'b1;
            cpu_hold_next = 1'b0;
          end else begin
            state_next = ERR;
            error_next = 1'b1;
          end
        end

        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  assign in_ready   = ready_int;
  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign cpu_hold   = cpu_hold_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign word_count = word_count_reg;

endmodule
